// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares a single-ported Wishbone-style memory bus between the instruction
// fetch stage (IF, read-only) and the load/store stage (MEM). One transaction
// is registered onto the bus at a time; the winner receives its read data and
// a one-cycle ack. MEM has fixed priority over IF because it carries the older
// instruction. A slave that never acknowledges is cut off after TIMEOUT bus
// cycles; the aborted requester still gets an ack, flagged with bus_err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           IF read request (held until if_ack)
//   if_rdata/if_ack          IF read data (held) and completion pulse
//   mem_req/we/addr/wdata/sel MEM request (held until mem_ack)
//   mem_rdata/mem_ack        MEM load data (held) and completion pulse
//   bus_err                  pulses with an ack that ended in a timeout
//   stallreq_if/stallreq_mem combinational stall requests to the stall control
//   bus_cyc/stb/we/addr/wdata/sel   bus master outputs (all registered)
//   bus_rdata/bus_ack        slave response
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [DW/8-1:0] mem_sel,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_ack,
    output logic            bus_err,
    output logic            stallreq_if,
    output logic            stallreq_mem,
    output logic            bus_cyc,
    output logic            bus_stb,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_sel,
    input  logic [DW-1:0]   bus_rdata,
    input  logic            bus_ack
);

    localparam int SW = DW / 8;
    // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_MEM = 2'd1,
        GNT_IF  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            cyc_reg, cyc_next;
    logic            we_reg, we_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [SW-1:0]   sel_reg, sel_next;
    logic [DW-1:0]   if_rdata_reg, if_rdata_next;
    logic [DW-1:0]   mem_rdata_reg, mem_rdata_next;
    logic            if_ack_reg, if_ack_next;
    logic            mem_ack_reg, mem_ack_next;
    logic            err_reg, err_next;

    // ------------------------------------------------------------------
    // State register and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            sel_reg       <= '0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            mem_ack_reg   <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cyc_reg       <= cyc_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            sel_reg       <= sel_next;
            if_rdata_reg  <= if_rdata_next;
            mem_rdata_reg <= mem_rdata_next;
            if_ack_reg    <= if_ack_next;
            mem_ack_reg   <= mem_ack_next;
            err_reg       <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cyc_next       = cyc_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        sel_next       = sel_reg;
        if_rdata_next  = if_rdata_reg;
        mem_rdata_next = mem_rdata_reg;
        // Acks and error are pulses: they only live for the cycle after
        // the completing edge.
        if_ack_next    = 1'b0;
        mem_ack_next   = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // A requester whose ack is currently high is still showing
                // the req of the transaction that just finished; skip it.
                if (mem_req && !mem_ack_reg) begin
                    state_next = GNT_MEM;
                    cyc_next   = 1'b1;
                    we_next    = mem_we;
                    addr_next  = mem_addr;
                    wdata_next = mem_wdata;
                    sel_next   = mem_sel;
                end else if (if_req && !if_ack_reg) begin
                    state_next = GNT_IF;
                    cyc_next   = 1'b1;
                    we_next    = 1'b0;
                    addr_next  = if_addr;
                    wdata_next = '0;
                    sel_next   = '1;
                end
            end

            GNT_MEM, GNT_IF: begin
                if (bus_ack) begin
                    // A late ack on the abort edge still counts as success.
                    if (state_reg == GNT_MEM) begin
                        mem_rdata_next = bus_rdata;
                        mem_ack_next   = 1'b1;
                    end else begin
                        if_rdata_next  = bus_rdata;
                        if_ack_next    = 1'b1;
                    end
                    state_next = IDLE;
                    cyc_next   = 1'b0;
                    we_next    = 1'b0;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    // Slave never answered: release the bus and complete
                    // the requester with zero data and an error flag.
                    if (state_reg == GNT_MEM) begin
                        mem_rdata_next = '0;
                        mem_ack_next   = 1'b1;
                    end else begin
                        if_rdata_next  = '0;
                        if_ack_next    = 1'b1;
                    end
                    err_next   = 1'b1;
                    state_next = IDLE;
                    cyc_next   = 1'b0;
                    we_next    = 1'b0;
                    addr_next  = '0;
                    wdata_next = '0;
                    sel_next   = '0;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cyc_next   = 1'b0;
                we_next    = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_cyc   = cyc_reg;
    assign bus_stb   = cyc_reg;
    assign bus_we    = we_reg;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign bus_sel   = sel_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;
    assign if_ack    = if_ack_reg;
    assign mem_ack   = mem_ack_reg;
    assign bus_err   = err_reg;

    // Stall requests must react within the same cycle, so they bypass the
    // registers; reset forces them low so the pipeline is never held in reset.
    assign stallreq_if  = if_req  & ~if_ack_reg  & ~rst;
    assign stallreq_mem = mem_req & ~mem_ack_reg & ~rst;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Bench for mem_bus_arbiter (AW=DW=32, TIMEOUT=15). A transaction-level
// reference model predicts every output each cycle; a vector table covers
// single transactions with chosen slave wait states, hand-written sequences
// cover simultaneous requests and reset mid-transaction, and a random phase
// exercises arbitrary request/ack/reset patterns.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_ack;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [3:0]      mem_sel;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;
    logic            bus_err;
    logic            stallreq_if;
    logic            stallreq_mem;
    logic            bus_cyc;
    logic            bus_stb;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [3:0]      bus_sel;
    logic [DW-1:0]   bus_rdata;
    logic            bus_ack;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .bus_err(bus_err),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction record plus the
    // completion results visible to the requesters.
    // ------------------------------------------------------------------
    bit          m_busy;        // a transaction owns the bus
    bit          m_owner_mem;   // 1 = MEM owns it, 0 = IF
    int          m_age;         // bus cycles the transaction has been on the bus
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_sel;
    bit          m_if_ack, m_mem_ack, m_err;
    logic [31:0] m_if_rdata, m_mem_rdata;

    task automatic model_finish(input logic [31:0] data, input bit err);
        if (m_owner_mem) begin
            m_mem_ack   = 1'b1;
            m_mem_rdata = data;
        end else begin
            m_if_ack    = 1'b1;
            m_if_rdata  = data;
        end
        m_err  = err;
        m_busy = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs present now.
    task automatic model_edge();
        bit was_if_ack, was_mem_ack;
        was_if_ack  = m_if_ack;
        was_mem_ack = m_mem_ack;
        m_if_ack  = 1'b0;
        m_mem_ack = 1'b0;
        m_err     = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_age = 0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_sel = '0;
            m_if_rdata = '0; m_mem_rdata = '0;
        end else if (m_busy) begin
            m_age++;
            if (bus_ack)
                model_finish(bus_rdata, 1'b0);
            else if (m_age == TIMEOUT)
                model_finish('0, 1'b1);
        end else if (mem_req && !was_mem_ack) begin
            m_busy = 1'b1; m_owner_mem = 1'b1; m_age = 0;
            m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_sel = mem_sel;
        end else if (if_req && !was_if_ack) begin
            m_busy = 1'b1; m_owner_mem = 1'b0; m_age = 0;
            m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_sel = 4'hF;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_stall();
        chk("stallreq_if",  {31'd0, stallreq_if},  {31'd0, if_req  & ~m_if_ack  & ~rst});
        chk("stallreq_mem", {31'd0, stallreq_mem}, {31'd0, mem_req & ~m_mem_ack & ~rst});
    endtask

    task automatic check_outputs();
        chk("bus_cyc",   {31'd0, bus_cyc}, {31'd0, m_busy});
        chk("bus_stb",   {31'd0, bus_stb}, {31'd0, m_busy});
        chk("bus_we",    {31'd0, bus_we},  {31'd0, m_busy & m_we});
        if (m_busy) begin
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_sel",  {28'd0, bus_sel}, {28'd0, m_sel});
            if (m_owner_mem) chk("bus_wdata", bus_wdata, m_wdata);
        end
        chk("if_ack",    {31'd0, if_ack},  {31'd0, m_if_ack});
        chk("mem_ack",   {31'd0, mem_ack}, {31'd0, m_mem_ack});
        chk("bus_err",   {31'd0, bus_err}, {31'd0, m_err});
        chk("if_rdata",  if_rdata,  m_if_rdata);
        chk("mem_rdata", mem_rdata, m_mem_rdata);
        if (m_if_ack || m_mem_ack) begin
            txn_no++;
            $display("txn %0d owner=%s err=%0d rdata=%h", txn_no,
                     m_mem_ack ? "MEM" : "IF", m_err,
                     m_mem_ack ? m_mem_rdata : m_if_rdata);
        end
    endtask

    // One clock: check combinational stalls, step the model, let the DUT
    // take the edge, then compare registered outputs at the falling edge.
    task automatic tick();
        #1;
        check_stall();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // ------------------------------------------------------------------
    // Vector table: one isolated transaction each. wait_cyc = number of
    // bus_cyc cycles without ack before the slave acks; -1 = never.
    // exp_lat = clock edges from request until the ack is visible.
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] slv_rdata;
        int          wait_cyc;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_we;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vector(input vec_t v, input int idx);
        int  cyc_seen;
        bit  got;
        bit  ack_now;
        cyc_seen = 0;
        got      = 1'b0;
        bus_ack  = 1'b0;
        bus_rdata = v.slv_rdata;
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
            mem_wdata = v.wdata; mem_sel = v.sel;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus_cyc) begin
                cyc_seen++;
                if (cyc_seen == 1) begin
                    chk($sformatf("vec%0d_bus_we", idx), {31'd0, bus_we}, {31'd0, v.exp_we});
                    chk($sformatf("vec%0d_bus_sel", idx), {28'd0, bus_sel}, {28'd0, v.exp_sel});
                end
            end
            ack_now = v.is_mem ? mem_ack : if_ack;
            if (ack_now) begin
                got = 1'b1;
                chk($sformatf("vec%0d_latency", idx), k, v.exp_lat);
                chk($sformatf("vec%0d_cyc_cycles", idx), cyc_seen, v.exp_lat - 1);
                chk($sformatf("vec%0d_rdata", idx), v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
                chk($sformatf("vec%0d_err", idx), {31'd0, bus_err}, {31'd0, v.exp_err});
                mem_req = 1'b0;
                if_req  = 1'b0;
                bus_ack = 1'b0;
                break;
            end
            bus_ack = (v.wait_cyc >= 0) && (cyc_seen == v.wait_cyc + 1);
        end
        if (!got) begin
            errors++;
            $display("FAIL vec%0d_no_ack: got none expected ack within 40 cycles", idx);
        end
        tick();
        chk($sformatf("vec%0d_ack_pulse", idx), {31'd0, if_ack | mem_ack}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int if_t, mem_t;

        //            mem we addr          wdata         sel    slv_rdata     wait lat rdata        err we sel
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF,  2,  4, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'hF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_1234, 4'b0011, 32'hAAAA_5555, 0, 2, 32'hAAAA_5555, 1'b0, 1'b1, 4'b0011};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 32'h1357_9BDF, -1, 16, 32'h0, 1'b1, 1'b0, 4'hF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'hF, 32'h0BAD_F00D, 14, 16, 32'h0BAD_F00D, 1'b0, 1'b0, 4'hF};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hCAFE_0001, 13, 15, 32'hCAFE_0001, 1'b0, 1'b0, 4'hF};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 32'hFFFF_FFFF, -1, 16, 32'h0, 1'b1, 1'b0, 4'hF};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'b1000, 32'h8765_4321, 0, 2, 32'h8765_4321, 1'b0, 1'b0, 4'b1000};

        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_sel = '0; bus_rdata = '0; bus_ack = 1'b0;
        m_busy = 1'b0; m_owner_mem = 1'b0; m_age = 0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_sel = '0;
        m_if_ack = 1'b0; m_mem_ack = 1'b0; m_err = 1'b0;
        m_if_rdata = '0; m_mem_rdata = '0;

        // Reset state
        tick();
        tick();
        chk("reset_bus_cyc",  {31'd0, bus_cyc}, 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_sel",  {28'd0, bus_sel}, 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_mem_ack",  {31'd0, mem_ack}, 32'd0);
        rst = 1'b0;
        tick();

        // Table of isolated transactions
        for (int i = 0; i < 7; i++)
            run_vector(vecs[i], i);

        // Simultaneous requests, zero-wait slave: MEM first, then IF
        if_req = 1'b1; if_addr = 32'h0000_0300;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0400; mem_sel = 4'hF;
        if_t = 0; mem_t = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (mem_ack && mem_t == 0) begin mem_t = k; mem_req = 1'b0; end
            if (if_ack && if_t == 0) begin if_t = k; if_req = 1'b0; end
            bus_ack   = bus_cyc;
            bus_rdata = $urandom;
        end
        chk("both_mem_ack_edge", mem_t, 2);
        chk("both_if_ack_edge",  if_t, 4);
        bus_ack = 1'b0;
        tick();

        // Reset in the middle of an IF transaction, then a late bus_ack
        if_req = 1'b1; if_addr = 32'h0000_0500;
        tick();
        tick();
        chk("pre_reset_cyc", {31'd0, bus_cyc}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_cyc",    {31'd0, bus_cyc}, 32'd0);
        chk("rst_mid_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_mid_addr",   bus_addr, 32'd0);
        chk("rst_mid_rdata",  if_rdata, 32'd0);
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        chk("late_ack_no_if_ack", {31'd0, if_ack}, 32'd0);
        chk("late_ack_regrant",   {31'd0, bus_cyc}, 32'd1);
        tick();
        chk("after_rst_if_ack",   {31'd0, if_ack}, 32'd1);
        chk("after_rst_if_rdata", if_rdata, 32'h1111_1111);
        if_req = 1'b0; bus_ack = 1'b0;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (mem_ack || !mem_req) mem_req = ($urandom_range(0, 3) == 0);
            if (if_ack || !if_req)   if_req  = ($urandom_range(0, 2) == 0);
            mem_we    = $urandom_range(0, 1);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_sel   = 4'($urandom_range(0, 15));
            if_addr   = $urandom;
            bus_ack   = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
